// File: rtl/rf_synth_prog_pkg.sv
// rf_synth_prog_pkg: shared types and constants for the RF synthesizer programmer.
//   state_e    FSM state encoding (idle, load, shift, latch, settle)
//   CH_BASE    channel 0 frequency code (2402)
//   FK_MAX     highest legal channel index (78)
//   RF_WORD_W  serial word width (16)
//   rf_word()  builds {addr, 12-bit channel code} from a channel index
package rf_synth_prog_pkg;

    localparam int unsigned RF_WORD_W = 16;
    localparam int unsigned FK_W      = 7;
    localparam int unsigned CH_W      = 12;

    localparam logic [CH_W-1:0] CH_BASE = 12'd2402;
    localparam logic [FK_W-1:0] FK_MAX  = 7'd78;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StLatch,
        StSettle
    } state_e;

    // 2402 + 78 = 2480 fits in 12 bits, so the add never wraps.
    function automatic logic [RF_WORD_W-1:0] rf_word(input logic [3:0]      addr,
                                                      input logic [FK_W-1:0] fk);
        logic [CH_W-1:0] ch;
        ch = CH_BASE + CH_W'(fk);
        return {addr, ch};
    endfunction

endpackage

// File: rtl/rf_synth_prog_if.sv
// rf_synth_prog_if: request and serial-bus signals of the RF synthesizer programmer.
//   regi_rf_en  enable (low forces idle)
//   fk          channel index 0..78
//   fk_chg_p    1-cycle pulse, fk holds a new channel
//   rf_sclk     serial clock to the synthesizer
//   rf_sdata    serial data, MSB first
//   rf_sle      latch enable
//   rf_busy     high whenever not idle
//   fkset_p     synthesizer settled on the latest channel
//   fk_err_p    illegal channel dropped
//   fk_ovr_p    pending request overwritten
// master: request side (hop/fk control). slave: the programmer.
interface rf_synth_prog_if;
    import rf_synth_prog_pkg::*;

    logic            regi_rf_en;
    logic [FK_W-1:0] fk;
    logic            fk_chg_p;
    logic            rf_sclk;
    logic            rf_sdata;
    logic            rf_sle;
    logic            rf_busy;
    logic            fkset_p;
    logic            fk_err_p;
    logic            fk_ovr_p;

    modport master (
        output regi_rf_en, fk, fk_chg_p,
        input  rf_sclk, rf_sdata, rf_sle, rf_busy, fkset_p, fk_err_p, fk_ovr_p
    );

    modport slave (
        input  regi_rf_en, fk, fk_chg_p,
        output rf_sclk, rf_sdata, rf_sle, rf_busy, fkset_p, fk_err_p, fk_ovr_p
    );

endinterface

// File: rtl/rf_synth_prog_sclk_gen.sv
// rf_synth_prog_sclk_gen: serial clock half-period divider.
//   i_clk     system clock
//   i_rst     synchronous active-high reset
//   i_en      run enable; low clears the divider and holds sclk low
//   o_sclk    serial clock level, starts low for SCLK_DIV cycles after enable
//   o_fall_p  strobe in the last high cycle (sclk falls at the next edge)
//   o_rise_p  strobe in the last low cycle (sclk rises at the next edge)
module rf_synth_prog_sclk_gen #(
    parameter int unsigned SCLK_DIV = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_fall_p,
    output logic o_rise_p
);

    localparam int unsigned     CntW    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SCLK_DIV - 1);

    logic [CntW-1:0] r_cnt;
    logic            r_sclk;
    logic            w_half_end;

    assign w_half_end = i_en && (r_cnt == CntLast);

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_half_end) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_sclk   = r_sclk;
    assign o_rise_p = w_half_end & ~r_sclk;
    assign o_fall_p = w_half_end & r_sclk;

endmodule

// File: rtl/rf_synth_prog.sv
// rf_synth_prog: writes each new hop channel to the RF synthesizer over a
// 3-wire serial bus and strobes fkset_p once the PLL has settled.
//   clk_6M  system clock (6 MHz)
//   rstz    synchronous active-high reset
//   bus     rf_synth_prog_if.slave: regi_rf_en, fk, fk_chg_p in;
//           rf_sclk, rf_sdata, rf_sle, rf_busy, fkset_p, fk_err_p, fk_ovr_p out
// Parameters: SCLK_DIV (cycles per sclk half-period), SETTLE_CYC (settle
// cycles after latch), RF_ADDR (synthesizer channel-register address).
module rf_synth_prog
    import rf_synth_prog_pkg::*;
#(
    parameter int unsigned SCLK_DIV   = 3,
    parameter int unsigned SETTLE_CYC = 900,
    parameter logic [3:0]  RF_ADDR    = 4'h1
) (
    input  logic           clk_6M,
    input  logic           rstz,
    rf_synth_prog_if.slave bus
);

    // One timer serves both the latch window and the settle wait.
    localparam int unsigned LatchCyc = 2 * SCLK_DIV;
    localparam int unsigned TmrMax   = (SETTLE_CYC > LatchCyc) ? SETTLE_CYC : LatchCyc;
    localparam int unsigned TmrW     = $clog2(TmrMax + 1);

    state_e                 r_state, w_state_d;
    logic [FK_W-1:0]        r_fk, w_fk_d;
    logic                   r_pend_vld, w_pend_vld_d;
    logic [FK_W-1:0]        r_pend_fk, w_pend_fk_d;
    logic [RF_WORD_W-1:0]   r_shift, w_shift_d;
    logic [3:0]             r_bit, w_bit_d;
    logic [TmrW-1:0]        r_tmr, w_tmr_d;
    logic                   r_fkset_p, w_fkset_d;
    logic                   r_err_p, w_err_d;
    logic                   r_ovr_p, w_ovr_d;

    logic w_req_ok;
    logic w_req_bad;
    logic w_in_shift;
    logic w_sclk;
    logic w_fall_p;
    logic w_rise_p;

    assign w_req_ok   = bus.fk_chg_p && (bus.fk <= FK_MAX);
    assign w_req_bad  = bus.fk_chg_p && (bus.fk > FK_MAX);
    assign w_in_shift = (r_state == StShift);

    rf_synth_prog_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .i_clk    (clk_6M),
        .i_rst    (rstz),
        .i_en     (w_in_shift),
        .o_sclk   (w_sclk),
        .o_fall_p (w_fall_p),
        .o_rise_p (w_rise_p)
    );

    always_comb begin
        w_state_d    = r_state;
        w_fk_d       = r_fk;
        w_pend_vld_d = r_pend_vld;
        w_pend_fk_d  = r_pend_fk;
        w_shift_d    = r_shift;
        w_bit_d      = r_bit;
        w_tmr_d      = r_tmr;
        w_fkset_d    = 1'b0;
        w_err_d      = 1'b0;
        w_ovr_d      = 1'b0;

        if (!bus.regi_rf_en) begin
            // Abandon everything; a partial word is never latched.
            w_state_d    = StIdle;
            w_pend_vld_d = 1'b0;
        end else begin
            if (w_req_bad) begin
                w_err_d = 1'b1;
            end

            // Requests during a word transfer go to the 1-deep pending slot.
            if (w_req_ok && (r_state == StLoad || r_state == StShift || r_state == StLatch)) begin
                w_pend_fk_d  = bus.fk;
                w_pend_vld_d = 1'b1;
                w_ovr_d      = r_pend_vld;
            end

            unique case (r_state)
                StIdle: begin
                    if (w_req_ok) begin
                        w_fk_d    = bus.fk;
                        w_state_d = StLoad;
                    end
                end
                StLoad: begin
                    w_shift_d = rf_word(RF_ADDR, r_fk);
                    w_bit_d   = '0;
                    w_state_d = StShift;
                end
                StShift: begin
                    if (w_rise_p) begin
                        w_bit_d = r_bit + 4'd1;
                    end
                    if (w_fall_p) begin
                        w_shift_d = {r_shift[RF_WORD_W-2:0], 1'b0};
                        // Every fall follows a rise, so a wrapped count here
                        // means all 16 bits have been clocked in.
                        if (r_bit == 4'd0) begin
                            w_state_d = StLatch;
                            w_tmr_d   = TmrW'(LatchCyc - 1);
                        end
                    end
                end
                StLatch: begin
                    if (r_tmr == '0) begin
                        if (w_pend_vld_d) begin
                            // Superseded word: skip the settle wait entirely.
                            w_fk_d       = w_pend_fk_d;
                            w_pend_vld_d = 1'b0;
                            w_state_d    = StLoad;
                        end else begin
                            w_state_d = StSettle;
                            w_tmr_d   = TmrW'(SETTLE_CYC - 1);
                        end
                    end else begin
                        w_tmr_d = r_tmr - 1'b1;
                    end
                end
                StSettle: begin
                    // A new channel wins over settle completion in the same cycle.
                    if (w_req_ok) begin
                        w_fk_d    = bus.fk;
                        w_state_d = StLoad;
                    end else if (r_tmr == '0) begin
                        w_fkset_d = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_tmr_d = r_tmr - 1'b1;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_6M) begin
        if (rstz) begin
            r_state    <= StIdle;
            r_fk       <= '0;
            r_pend_vld <= 1'b0;
            r_pend_fk  <= '0;
            r_shift    <= '0;
            r_bit      <= '0;
            r_tmr      <= '0;
            r_fkset_p  <= 1'b0;
            r_err_p    <= 1'b0;
            r_ovr_p    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_fk       <= w_fk_d;
            r_pend_vld <= w_pend_vld_d;
            r_pend_fk  <= w_pend_fk_d;
            r_shift    <= w_shift_d;
            r_bit      <= w_bit_d;
            r_tmr      <= w_tmr_d;
            r_fkset_p  <= w_fkset_d;
            r_err_p    <= w_err_d;
            r_ovr_p    <= w_ovr_d;
        end
    end

    // Gate serial outputs by state so an aborted shift drops them at once.
    assign bus.rf_sclk  = w_sclk & w_in_shift;
    assign bus.rf_sdata = r_shift[RF_WORD_W-1] & w_in_shift;
    assign bus.rf_sle   = (r_state == StLatch);
    assign bus.rf_busy  = (r_state != StIdle);
    assign bus.fkset_p  = r_fkset_p;
    assign bus.fk_err_p = r_err_p;
    assign bus.fk_ovr_p = r_ovr_p;

endmodule
